gray_counter_conv: RTL and testbench
====================================

Name: gray_counter_conv

Overview:
- Parametrised successor to the team's 3-bit combinational binary-to-Gray converter.
- Synchronous up/down counter that holds a binary count and presents registered binary and Gray-coded outputs.
- Supports parallel load in either binary or Gray encoding and flags wrap-around.
- Used as a pointer/sequence source wherever single-bit-change codes are needed, e.g. FIFO pointers and encoder test sequences.

Parameters:
- WIDTH, 3: count width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; one step per clk while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- load_is_gray  input  1  encoding of load_val: 1 = Gray, 0 = binary.
- load_val  input  WIDTH  value to load.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out.
- tc  output  1  registered one-cycle terminal-count (wrap) pulse.

Behaviour:
- Reset and edge behaviour:
  - Reset is synchronous and active-high; single clock domain.
  - All state updates on the rising edge of clk.
  - While rst is high at an edge: bin_out=0, gray_out=0, tc=0. rst has priority over every other input.
- Per-edge priority: rst > load > en > hold.
- Load (load=1, rst=0):
  - If load_is_gray=0: next bin = load_val.
  - If load_is_gray=1: next bin = gray2bin(load_val), where bin[WIDTH-1]=g[WIDTH-1] and bin[i]=bin[i+1]^g[i] for i descending.
  - tc=0 on a load cycle, even if en=1. en is ignored that cycle.
- Count (en=1, load=0, rst=0):
  - up_dn=1: next bin = bin+1, modulo 2^WIDTH.
  - up_dn=0: next bin = bin-1, modulo 2^WIDTH.
- Hold (en=0, load=0, rst=0): bin unchanged; tc=0.
- Gray output:
  - gray_out is always (next bin) ^ ((next bin)>>1), registered in the same edge as bin_out.
  - gray_out and bin_out are never a cycle apart.
- Latency: one clk from sampled inputs to updated outputs. No combinational path from inputs to outputs.
- Terminal count tc:
  - tc=1 for exactly the one cycle following a counting edge that wraps: up from all-ones to 0, or down from 0 to all-ones.
  - tc=0 otherwise.
  - A direction change at the boundary (e.g. at 0 with up_dn switching from 1 to 0, then en) wraps down and sets tc.
- Single-bit-change property: on every count step (not load), gray_out differs from its previous value in exactly one bit, including across the wrap.
- Reset mid-operation: count restarts at 0 on the next edge regardless of en, load or up_dn. Counting resumes from 0 on the first edge with rst low and en high.
- No internal state other than the bin register and the tc register. gray_out may be implemented as its own register or as a registered function of the bin register, but it must be glitch-free at the output register.

Test Plan:
- Reset with WIDTH=3: rst=1 for 2 cycles, en=1, load=1 -> bin_out=000, gray_out=000, tc=0 each cycle.
- Up count, WIDTH=3, en=1, up_dn=1 from 0 for 9 cycles:
  - gray_out must be 001,011,010,110,111,101,100,000,001.
  - bin_out must be 1..7,0,1.
  - tc=1 only on the cycle where bin_out=000.
- Down count: from 0 with en=1, up_dn=0 -> bin_out=111 with gray_out=100 and tc=1, then 110/101 with tc=0.
- Gray load: load=1, load_is_gray=1, load_val=110 -> bin_out=100, gray_out=110 next cycle. Same with load_is_gray=0 -> bin_out=110, gray_out=101.
- Priority: load=1 and en=1 with load_val=011 binary -> bin_out=011, tc=0. rst=1 together with load=1 -> bin_out=000.
- Reset mid-count and WIDTH=8 sweep:
  - Assert rst at bin_out=101 -> 000 next edge; with en=1 after release -> 001.
  - With WIDTH=8, 300 up steps: checker confirms exactly one gray_out bit flips per step and tc pulses once at the 255->0 transition.

Source files
------------

// File: rtl/gray_counter_conv.sv
// rtl/gray_counter_conv.sv - up/down counter with registered binary and Gray outputs, load and wrap flag
module gray_counter_conv #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_next;
  logic             tc_next;

  // Gray-to-binary is a running XOR from the MSB down; the accumulator avoids a self-referencing vector
  always_comb begin : gray_to_bin
    logic acc;
    acc = 1'b0;
    load_bin = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc = acc ^ load_val[i];
      load_bin[i] = acc;
    end
  end

  always_comb begin
    bin_next = bin_out;
    tc_next  = 1'b0;
    if (load) begin
      bin_next = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      if (up_dn) begin
        bin_next = bin_out + ONE;
        tc_next  = &bin_out;
      end else begin
        bin_next = bin_out - ONE;
        tc_next  = ~|bin_out;
      end
    end
  end

  // Gray is registered from the same next value so both outputs change on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      tc       <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= bin_next ^ (bin_next >> 1);
      tc       <= tc_next;
    end
  end

endmodule

// File: tb/tb_gray_counter_conv.sv
// tb/tb_gray_counter_conv.sv - randomized and directed bench for gray_counter_conv at WIDTH 3 and 8
module tb_gray_counter_conv;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, load_is_gray;
  logic [7:0] load_val8;
  logic [2:0] load_val3;
  logic [2:0] bin3, gray3;
  logic [7:0] bin8, gray8;
  logic       tc3, tc8;

  int n_tests = 0;
  int n_fail  = 0;
  int m3_bin = 0, m3_tc = 0, m8_bin = 0, m8_tc = 0;

  assign load_val3 = load_val8[2:0];

  always #5 clk = ~clk;

  gray_counter_conv #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val3),
    .bin_out(bin3), .gray_out(gray3), .tc(tc3)
  );

  gray_counter_conv #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val8),
    .bin_out(bin8), .gray_out(gray8), .tc(tc8)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Decode by search: the binary value whose Gray image equals g
  function automatic int from_gray(input int w, input int g);
    for (int b = 0; b < (1 << w); b++)
      if (to_gray(b) == g) return b;
    return -1;
  endfunction

  task automatic model_step(input int w, inout int bin, inout int tc_m);
    int lim, lv;
    lim = 1 << w;
    lv  = int'(load_val8) % lim;
    if (rst) begin
      bin = 0; tc_m = 0;
    end else if (load) begin
      bin  = load_is_gray ? from_gray(w, lv) : lv;
      tc_m = 0;
    end else if (en) begin
      if (up_dn) begin
        tc_m = (bin + 1 == lim) ? 1 : 0;
        bin  = (bin + 1) % lim;
      end else begin
        tc_m = (bin == 0) ? 1 : 0;
        bin  = (bin + lim - 1) % lim;
      end
    end else begin
      tc_m = 0;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic lg, input int lv);
    rst = r; en = e; up_dn = u; load = l; load_is_gray = lg; load_val8 = lv[7:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(3, m3_bin, m3_tc);
    model_step(8, m8_bin, m8_tc);
    #1;
    check("bin3",  int'(bin3),  m3_bin);
    check("gray3", int'(gray3), to_gray(m3_bin));
    check("tc3",   int'(tc3),   m3_tc);
    check("bin8",  int'(bin8),  m8_bin);
    check("gray8", int'(gray8), to_gray(m8_bin));
    check("tc8",   int'(tc8),   m8_tc);
  endtask

  initial begin
    int exp_gray [9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    int prev, tc_pulses;

    drive(1, 1, 1, 1, 0, 5);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_bin", int'(bin3), 0);
      check("rst_gray", int'(gray3), 0);
      check("rst_tc", int'(tc3), 0);
    end

    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("up_gray", int'(gray3), exp_gray[i]);
      check("up_bin", int'(bin3), (i + 1) % 8);
      check("up_tc", int'(tc3), (i == 7) ? 1 : 0);
    end

    drive(1, 0, 1, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    tick();
    check("dn_bin", int'(bin3), 7);
    check("dn_gray", int'(gray3), 4);
    check("dn_tc", int'(tc3), 1);
    tick();
    check("dn_bin6", int'(bin3), 6);
    check("dn_tc6", int'(tc3), 0);
    tick();
    check("dn_bin5", int'(bin3), 5);
    check("dn_tc5", int'(tc3), 0);

    drive(0, 0, 1, 1, 1, 6);
    tick();
    check("gl_bin", int'(bin3), 4);
    check("gl_gray", int'(gray3), 6);
    drive(0, 0, 1, 1, 0, 6);
    tick();
    check("bl_bin", int'(bin3), 6);
    check("bl_gray", int'(gray3), 5);

    drive(0, 0, 1, 1, 0, 7);
    tick();
    drive(0, 1, 1, 1, 0, 3);
    tick();
    check("pri_bin", int'(bin3), 3);
    check("pri_tc", int'(tc3), 0);
    drive(1, 1, 1, 1, 0, 3);
    tick();
    check("pri_rst", int'(bin3), 0);

    drive(0, 0, 1, 1, 0, 5);
    tick();
    check("mid_load", int'(bin3), 5);
    drive(1, 1, 1, 0, 0, 0);
    tick();
    check("mid_rst", int'(bin3), 0);
    drive(0, 1, 1, 0, 0, 0);
    tick();
    check("mid_resume", int'(bin3), 1);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 255));
      tick();
    end

    drive(1, 0, 1, 0, 0, 0);
    tick();
    drive(0, 1, 1, 0, 0, 0);
    prev = int'(gray8);
    tc_pulses = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      check("flip8", $countones(gray8 ^ prev[7:0]), 1);
      prev = int'(gray8);
      if (tc8) begin
        tc_pulses++;
        check("wrap8_bin", int'(bin8), 0);
      end
    end
    check("tc8_pulses", tc_pulses, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
